// File: rtl/led_message_scheduler_if.sv
// Host/driver-side signals of the LED message scheduler: message writes,
// run control and the registered four-character display window.
interface led_message_scheduler_if #(
  parameter int MSG_LEN = 16,
  parameter int AW      = $clog2(MSG_LEN)
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_ready;
  logic          start;
  logic          stop;
  logic          step;
  logic [3:0]    digit3;
  logic [3:0]    digit2;
  logic [3:0]    digit1;
  logic [3:0]    digit0;
  logic          window_valid;
  logic [AW-1:0] msg_ptr;
  logic          wrap;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, step,
    input  wr_ready, digit3, digit2, digit1, digit0, window_valid, msg_ptr, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, step,
    output wr_ready, digit3, digit2, digit1, digit0, window_valid, msg_ptr, wrap
  );
endinterface

// File: rtl/led_message_scheduler.sv
// Scrolls a writable message buffer through a 4-digit display window.
// Optional SCROLL_BOUNCE_EN: ping-pong between 0 and MSG_LEN-4 instead of wrapping.
module led_message_scheduler #(
  parameter int         MSG_LEN    = 16,
  parameter int         SCROLL_DIV = 4,
  parameter int         CNT_W      = 25,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic                    clk,
  input logic                    reset,
  led_message_scheduler_if.slave bus
);
  localparam int                AW       = $clog2(MSG_LEN);
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SCROLL_DIV - 1);
  localparam logic [AW-1:0]     PTR_LAST = AW'(MSG_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0] div, div_nxt;
  logic             wrap_q, wrap_nxt;
  logic             advance;
  logic             restart;
  logic [AW-1:0]    adv_ptr;
  logic             adv_wrap;
  logic             wr_ready;
  logic [3:0]       msg_buf [MSG_LEN];
  logic [3:0]       win     [4];

`ifdef SCROLL_BOUNCE_EN
  localparam logic [AW-1:0] PTR_TOP = AW'(MSG_LEN - 4);
  logic dir_up;

  // A step at either end reverses direction and moves one position back.
  always_comb begin
    adv_wrap = 1'b0;
    if (dir_up) begin
      if (ptr == PTR_TOP) begin
        adv_ptr  = ptr - AW'(1);
        adv_wrap = 1'b1;
      end else begin
        adv_ptr  = ptr + AW'(1);
      end
    end else begin
      if (ptr == '0) begin
        adv_ptr  = AW'(1);
        adv_wrap = 1'b1;
      end else begin
        adv_ptr  = ptr - AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                  dir_up <= 1'b1;
    else if (restart)            dir_up <= 1'b1;
    else if (advance && adv_wrap) dir_up <= ~dir_up;
  end
`else
  always_comb begin
    adv_ptr  = ptr + AW'(1);
    adv_wrap = (ptr == PTR_LAST);
  end
`endif

  assign wr_ready = (state != RUN);

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    div_nxt   = div;
    advance   = 1'b0;
    restart   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
          div_nxt   = '0;
          restart   = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = PAUSE;
        end else if (div == DIV_LAST) begin
          div_nxt = '0;
          advance = 1'b1;
        end else begin
          div_nxt = div + CNT_W'(1);
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          div_nxt   = '0;
        end else if (bus.start) begin
          state_nxt = RUN;
        end else if (bus.step) begin
          advance = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (advance) ptr_nxt = adv_ptr;
    wrap_nxt = advance && adv_wrap;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      div    <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      div    <= div_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // NOTE: the buffer is reset to blanks so power-up shows nothing; this keeps it in flops, not RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= BLANK_CODE;
    end else if (bus.wr_en && wr_ready) begin
      msg_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // win[k] drives digitK; digit3 is the leftmost character at msg_ptr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) win[k] <= BLANK_CODE;
    end else begin
      for (int k = 0; k < 4; k++)
        win[k] <= (state == IDLE) ? BLANK_CODE : msg_buf[ptr + AW'(3 - k)];
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.window_valid = (state != IDLE);
  assign bus.msg_ptr      = ptr;
  assign bus.wrap         = wrap_q;
  assign bus.digit3       = win[3];
  assign bus.digit2       = win[2];
  assign bus.digit1       = win[1];
  assign bus.digit0       = win[0];
endmodule

// File: tb/tb_led_message_scheduler.sv
// Bench for led_message_scheduler: directed scenarios with literal expectations
// plus randomized control/write traffic, all compared to a behavioural model.
module tb_led_message_scheduler;
  localparam int L   = 16;
  localparam int DIV = 4;

  logic clk;
  logic reset;

  led_message_scheduler_if #(.MSG_LEN(L)) bus ();

  led_message_scheduler #(
    .MSG_LEN(L), .SCROLL_DIV(DIV), .CNT_W(25), .BLANK_CODE(4'hF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  wire [15:0] dut_dig = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};

  // Behavioural model: mode 0 = idle, 1 = running, 2 = paused.
  int         m_mode = 0;
  int         m_ptr  = 0;
  int         m_cnt  = 0;
  bit         m_up   = 1'b1;
  bit         m_wrap = 1'b0;
  logic [3:0] m_buf [L];
  logic [15:0] m_dig = 16'hFFFF;

  task automatic m_advance();
`ifdef SCROLL_BOUNCE_EN
    if (m_up) begin
      if (m_ptr == L - 4) begin m_ptr--; m_up = 1'b0; m_wrap = 1'b1; end
      else m_ptr++;
    end else begin
      if (m_ptr == 0) begin m_ptr = 1; m_up = 1'b1; m_wrap = 1'b1; end
      else m_ptr--;
    end
`else
    m_wrap = (m_ptr == L - 1);
    m_ptr  = (m_ptr + 1) % L;
`endif
  endtask

  task automatic m_clock();
    logic [15:0] w;
    if (!reset) begin
      m_mode = 0; m_ptr = 0; m_cnt = 0; m_up = 1'b1; m_wrap = 1'b0;
      for (int i = 0; i < L; i++) m_buf[i] = 4'hF;
      m_dig = 16'hFFFF;
    end else begin
      w = 16'hFFFF;
      if (m_mode != 0)
        for (int k = 0; k < 4; k++) w[k*4 +: 4] = m_buf[(m_ptr + 3 - k) % L];
      m_wrap = 1'b0;
      if (bus.wr_en && m_mode != 1) m_buf[bus.wr_addr] = bus.wr_data;
      case (m_mode)
        0: if (!bus.stop && bus.start) begin m_mode = 1; m_ptr = 0; m_cnt = 0; m_up = 1'b1; end
        1: begin
          if (bus.stop) m_mode = 2;
          else if (m_cnt == DIV - 1) begin m_cnt = 0; m_advance(); end
          else m_cnt++;
        end
        default: begin
          if (bus.stop) begin m_mode = 0; m_ptr = 0; m_cnt = 0; end
          else if (bus.start) m_mode = 1;
          else if (bus.step) m_advance();
        end
      endcase
      m_dig = w;
    end
  endtask

  // Single compare process: update the model at each edge, then check 1 time unit later.
  always @(posedge clk) begin
    m_clock();
    #1;
    check("cyc_digits",   dut_dig,          m_dig);
    check("cyc_valid",    bus.window_valid, (m_mode != 0));
    check("cyc_wr_ready", bus.wr_ready,     (m_mode != 1));
    check("cyc_msg_ptr",  bus.msg_ptr,      m_ptr);
    check("cyc_wrap",     bus.wrap,         m_wrap);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
  endtask
  task automatic pulse_step();
    bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
  endtask
  task automatic write(input int addr, input logic [3:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(addr); bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
    cyc(2);
    check("rst_digits",   dut_dig,          16'hFFFF);
    check("rst_valid",    bus.window_valid, 0);
    check("rst_wr_ready", bus.wr_ready,     1);
    check("rst_msg_ptr",  bus.msg_ptr,      0);
    reset = 1'b1;

    for (int i = 0; i < L; i++) write(i, 4'(i));
    check("idle_digits", dut_dig, 16'hFFFF);

    pulse_start();
    cyc(1);
    check("start_digits", dut_dig, 16'h0123);
    check("model_pin_start", m_dig, 16'h0123);
    cyc(4);
    check("scroll_digits", dut_dig, 16'h1234);
    check("model_pin_scroll", m_dig, 16'h1234);

`ifndef SCROLL_BOUNCE_EN
    n = 0;
    while (bus.msg_ptr != 4'd15 && n < 100) begin @(negedge clk); n++; end
    check("reach_ptr15", bus.msg_ptr, 15);
    cyc(1);
    check("ptr15_digits", dut_dig, 16'hF012);
    n = 0;
    while (bus.wrap !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("wrap_high", bus.wrap, 1);
    check("wrap_ptr0", bus.msg_ptr, 0);
    cyc(1);
    check("wrap_one_cycle", bus.wrap, 0);
    check("post_wrap_digits", dut_dig, 16'h0123);
`else
    n = 0;
    while (bus.msg_ptr != 4'd12 && n < 100) begin @(negedge clk); n++; end
    check("reach_ptr12", bus.msg_ptr, 12);
    n = 0;
    while (bus.wrap !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("bounce_wrap", bus.wrap, 1);
    check("bounce_ptr11", bus.msg_ptr, 11);
    cyc(1);
    check("bounce_wrap_one_cycle", bus.wrap, 0);
`endif

    // Realign: RUN -> PAUSE -> IDLE -> RUN, so pointer and divider restart at 0.
    pulse_stop();
    pulse_stop();
    pulse_start();
    cyc(1);
    check("restart_digits", dut_dig, 16'h0123);
    cyc(1);
    pulse_stop();
    cyc(20);
    check("pause_frozen_digits", dut_dig, 16'h0123);
    check("pause_frozen_ptr", bus.msg_ptr, 0);
    pulse_step();
    cyc(1);
    check("step_digits", dut_dig, 16'h1234);
    pulse_start();
    cyc(1);
    check("resume_ptr_hold", bus.msg_ptr, 1);
    cyc(1);
    check("resume_ptr_adv", bus.msg_ptr, 2);

    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 4'hA;
    #1;
    check("run_wr_ready", bus.wr_ready, 0);
    @(negedge clk);
    bus.wr_en = 1'b0;

    pulse_stop();
    n = 0;
    while (bus.msg_ptr != 4'd3 && n < 40) begin pulse_step(); n++; end
    check("pause_ptr3", bus.msg_ptr, 3);
    cyc(1);
    check("run_write_dropped", dut_dig, 16'h3456);
    write(5, 4'hA);
    check("pause_write_lag", dut_dig, 16'h3456);
    cyc(1);
    check("pause_write_digit1", bus.digit1, 4'hA);
    check("pause_write_digits", dut_dig, 16'h34A6);

    pulse_stop();
    check("stop_to_idle_valid", bus.window_valid, 0);
    check("stop_to_idle_ptr", bus.msg_ptr, 0);
    cyc(1);
    check("idle_blank", dut_dig, 16'hFFFF);

    pulse_start();
    cyc(6);
    reset = 1'b0;
    cyc(1);
    check("midrun_rst_digits", dut_dig, 16'hFFFF);
    check("midrun_rst_valid", bus.window_valid, 0);
    check("midrun_rst_ready", bus.wr_ready, 1);
    check("midrun_rst_ptr", bus.msg_ptr, 0);
    check("midrun_rst_wrap", bus.wrap, 0);
    reset = 1'b1;
    pulse_start();
    cyc(1);
    check("buf_cleared", dut_dig, 16'hFFFF);
    check("buf_cleared_valid", bus.window_valid, 1);

    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 149) != 0);
      bus.start = ($urandom_range(0, 9) == 0);
      bus.stop  = ($urandom_range(0, 24) == 0);
      bus.step  = ($urandom_range(0, 5) == 0);
      bus.wr_en = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 4'($urandom_range(0, L - 1));
      bus.wr_data = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.wr_en = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
